mmio_arbiter: RTL and testbench

Two-master arbiter and sequencer for the word-addressed memory-mapped I/O slave bus (word maps, LED register). It accepts single-word read/write requests from the core load/store port (master 0) and the debug/loader port (master 1), arbitrates round-robin, and drives one registered access per grant onto the shared slave bus. It range-checks each address against the slave window and returns read data or an error to the requester with a one-cycle ack.

---
 rtl/mmio_arbiter_if.sv | 43 ++++
 rtl/mmio_arbiter.sv | 137 +++++++++++++
 tb/tb_mmio_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_arbiter_if.sv
// Bundle of both master ports and the shared slave bus of mmio_arbiter.
// The slave modport is the arbiter's view; master is the environment's.
interface mmio_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [29:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m0_ack;
    logic [31:0] m0_rd;
    logic        m0_err;

    logic        m1_req;
    logic        m1_we;
    logic [29:0] m1_addr;
    logic [31:0] m1_wd;
    logic        m1_ack;
    logic [31:0] m1_rd;
    logic        m1_err;

    logic        bus_re;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wd;
    logic [31:0] bus_rd;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        output m0_ack, m0_rd, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wd,
        output m1_ack, m1_rd, m1_err,
        output bus_re, bus_we, bus_addr, bus_wd,
        input  bus_rd
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        input  m0_ack, m0_rd, m0_err,
        output m1_req, m1_we, m1_addr, m1_wd,
        input  m1_ack, m1_rd, m1_err,
        input  bus_re, bus_we, bus_addr, bus_wd,
        output bus_rd
    );
endinterface

// File: rtl/mmio_arbiter.sv
// Two-master round-robin arbiter and single-access sequencer for the
// word-addressed MMIO slave bus, with window range check and ack/err return.
module mmio_arbiter #(
    parameter int          WORDS = 4,
    parameter logic [31:0] BASE  = 32'h0
) (
    input  logic           clk,
    input  logic           reset,
    mmio_arbiter_if.slave  io
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam logic [29:0] BASE_W  = BASE[31:2];
    localparam logic [30:0] WORDS_W = 31'(WORDS);

    state_t      state;
    state_t      next_state;

    logic        last_grant;
    logic        sel;
    logic        we_r;
    logic        in_r;
    logic [29:0] addr_r;
    logic [31:0] wd_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic        grant;
    logic        gsel;
    logic        g_we;
    logic [29:0] g_addr;
    logic [31:0] g_wd;
    logic [30:0] diff;
    logic        g_in;

    assign g_we   = gsel ? io.m1_we   : io.m0_we;
    assign g_addr = gsel ? io.m1_addr : io.m0_addr;
    assign g_wd   = gsel ? io.m1_wd   : io.m0_wd;

    // 31-bit difference: bit 30 set means the address lies below BASE
    assign diff = {1'b0, g_addr} - {1'b0, BASE_W};
    assign g_in = !diff[30] && ({1'b0, diff[29:0]} < WORDS_W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // In RESP only the master not just served may be granted
    always_comb begin
        next_state = state;
        grant      = 1'b0;
        gsel       = 1'b0;
        unique case (state)
            IDLE: begin
                if (io.m0_req || io.m1_req) begin
                    grant      = 1'b1;
                    gsel       = io.m1_req && (!io.m0_req || !last_grant);
                    next_state = BUS;
                end
            end
            BUS: begin
                next_state = RESP;
            end
            RESP: begin
                next_state = IDLE;
                if (sel ? io.m0_req : io.m1_req) begin
                    grant      = 1'b1;
                    gsel       = !sel;
                    next_state = BUS;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            sel        <= 1'b0;
            we_r       <= 1'b0;
            in_r       <= 1'b0;
            addr_r     <= '0;
            wd_r       <= '0;
            rdata_r    <= '0;
            err_r      <= 1'b0;
        end else begin
            if (grant) begin
                last_grant <= gsel;
                sel        <= gsel;
                we_r       <= g_we;
                in_r       <= g_in;
                addr_r     <= diff[29:0];
                wd_r       <= g_wd;
            end
            if (state == BUS) begin
                rdata_r <= (in_r && !we_r) ? io.bus_rd : '0;
                err_r   <= !in_r;
            end
        end
    end

    always_comb begin
        io.bus_re   = 1'b0;
        io.bus_we   = 1'b0;
        io.bus_addr = '0;
        io.bus_wd   = '0;
        io.m0_ack   = 1'b0;
        io.m0_rd    = '0;
        io.m0_err   = 1'b0;
        io.m1_ack   = 1'b0;
        io.m1_rd    = '0;
        io.m1_err   = 1'b0;
        if (state == BUS && in_r) begin
            io.bus_re   = !we_r;
            io.bus_we   = we_r;
            io.bus_addr = addr_r;
            io.bus_wd   = we_r ? wd_r : '0;
        end
        if (state == RESP) begin
            if (sel) begin
                io.m1_ack = 1'b1;
                io.m1_rd  = rdata_r;
                io.m1_err = err_r;
            end else begin
                io.m0_ack = 1'b1;
                io.m0_rd  = rdata_r;
                io.m0_err = err_r;
            end
        end
    end
endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: a cycle vector table on a BASE=0 instance
// plus hand sequences for range errors, sustained contention and mid-access reset.
module tb_mmio_arbiter;
    localparam logic [31:0] D0 = 32'hDEADBEEF;
    localparam logic [31:0] D1 = 32'h11111111;
    localparam logic [31:0] D3 = 32'h33333333;
    localparam logic [31:0] DB = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mmio_arbiter_if a_if();
    mmio_arbiter_if b_if();

    mmio_arbiter #(.WORDS(4), .BASE(32'h0)) dut_a (
        .clk(clk), .reset(reset), .io(a_if)
    );
    mmio_arbiter #(.WORDS(4), .BASE(32'h10)) dut_b (
        .clk(clk), .reset(reset), .io(b_if)
    );

    logic [31:0] mem [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    assign a_if.bus_rd = mem[a_if.bus_addr[1:0]];
    always @(posedge clk) begin
        if (a_if.bus_we) mem[a_if.bus_addr[1:0]] <= a_if.bus_wd;
    end
    assign b_if.bus_rd = DB;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        re;
        logic        we;
        logic [29:0] addr;
        logic [31:0] wd;
        logic        a0;
        logic [31:0] rd0;
        logic        e0;
        logic        a1;
        logic [31:0] rd1;
        logic        e1;
    } obs_t;

    typedef struct {
        logic        r0;
        logic        w0;
        logic [29:0] ad0;
        logic [31:0] wd0;
        logic        r1;
        logic        w1;
        logic [29:0] ad1;
        logic [31:0] wd1;
        obs_t        exp;
    } vec_t;

    function automatic obs_t sample_a();
        obs_t s;
        s.re = a_if.bus_re;   s.we = a_if.bus_we;
        s.addr = a_if.bus_addr; s.wd = a_if.bus_wd;
        s.a0 = a_if.m0_ack;   s.rd0 = a_if.m0_rd; s.e0 = a_if.m0_err;
        s.a1 = a_if.m1_ack;   s.rd1 = a_if.m1_rd; s.e1 = a_if.m1_err;
        return s;
    endfunction

    function automatic obs_t ob_bus(logic re, logic we, logic [29:0] ad,
                                    logic [31:0] wd);
        obs_t s = '0;
        s.re = re; s.we = we; s.addr = ad; s.wd = wd;
        return s;
    endfunction

    function automatic obs_t ob_ack(logic m, logic [31:0] rd, logic err);
        obs_t s = '0;
        if (m) begin s.a1 = 1'b1; s.rd1 = rd; s.e1 = err; end
        else   begin s.a0 = 1'b1; s.rd0 = rd; s.e0 = err; end
        return s;
    endfunction

    function automatic vec_t mk(logic r0, logic w0, logic [29:0] ad0,
                                logic [31:0] wd0, logic r1, logic w1,
                                logic [29:0] ad1, logic [31:0] wd1, obs_t e);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.ad0 = ad0; v.wd0 = wd0;
        v.r1 = r1; v.w1 = w1; v.ad1 = ad1; v.wd1 = wd1;
        v.exp = e;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, got, exp);
        end
    endtask

    task automatic chk_obs(input string n, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, got, exp);
        end
    endtask

    task automatic drop_all();
        a_if.m0_req = 0; a_if.m0_we = 0; a_if.m0_addr = '0; a_if.m0_wd = '0;
        a_if.m1_req = 0; a_if.m1_we = 0; a_if.m1_addr = '0; a_if.m1_wd = '0;
        b_if.m0_req = 0; b_if.m0_we = 0; b_if.m0_addr = '0; b_if.m0_wd = '0;
        b_if.m1_req = 0; b_if.m1_we = 0; b_if.m1_addr = '0; b_if.m1_wd = '0;
    endtask

    task automatic a_access(input logic m, input logic we,
                            input logic [29:0] ad, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input string n);
        logic        got = 1'b0;
        logic [31:0] rd = '0;
        @(negedge clk);
        if (m) begin
            a_if.m1_req = 1; a_if.m1_we = we; a_if.m1_addr = ad; a_if.m1_wd = wd;
        end else begin
            a_if.m0_req = 1; a_if.m0_we = we; a_if.m0_addr = ad; a_if.m0_wd = wd;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (m ? a_if.m1_ack : a_if.m0_ack) begin
                got = 1'b1;
                rd = m ? a_if.m1_rd : a_if.m0_rd;
                break;
            end
        end
        a_if.m0_req = 0; a_if.m1_req = 0;
        chk({n, " ack"}, {31'b0, got}, 32'd1);
        chk({n, " rd"}, rd, exp_rd);
    endtask

    task automatic b_read(input logic [29:0] ad, input logic [31:0] exp_rd,
                          input logic exp_err, input logic [29:0] exp_ba,
                          input string n);
        logic        got = 1'b0;
        logic        saw_re = 1'b0;
        logic        saw_we = 1'b0;
        logic [29:0] ba = '0;
        logic [31:0] rd = '0;
        logic        err = 1'b0;
        @(negedge clk);
        b_if.m1_req = 1; b_if.m1_we = 0; b_if.m1_addr = ad;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            saw_we |= b_if.bus_we;
            if (b_if.bus_re) begin saw_re = 1'b1; ba = b_if.bus_addr; end
            if (b_if.m1_ack) begin
                got = 1'b1; rd = b_if.m1_rd; err = b_if.m1_err;
                break;
            end
        end
        b_if.m1_req = 0;
        chk({n, " ack"}, {31'b0, got}, 32'd1);
        chk({n, " err"}, {31'b0, err}, {31'b0, exp_err});
        chk({n, " rd"}, rd, exp_rd);
        chk({n, " bus_re"}, {31'b0, saw_re}, {31'b0, !exp_err});
        chk({n, " bus_we"}, {31'b0, saw_we}, 32'd0);
        chk({n, " bus_addr"}, {2'b0, ba}, {2'b0, exp_ba});
    endtask

    vec_t tbl[20];

    initial begin
        logic        n_prev;
        logic        cur;
        logic        acked;
        int          n;
        int          last_c;

        drop_all();
        tbl[0]  = mk(0,0,0,0,   0,0,0,0,   '0);
        tbl[1]  = mk(1,1,2,D0,  1,1,1,D1,  '0);
        tbl[2]  = mk(1,1,2,D0,  1,1,1,D1,  ob_bus(0,1,2,D0));
        tbl[3]  = mk(1,1,2,D0,  1,1,1,D1,  ob_ack(0,0,0));
        tbl[4]  = mk(0,0,0,0,   1,1,1,D1,  ob_bus(0,1,1,D1));
        tbl[5]  = mk(0,0,0,0,   1,1,1,D1,  ob_ack(1,0,0));
        tbl[6]  = mk(1,0,2,0,   0,0,0,0,   '0);
        tbl[7]  = mk(1,0,2,0,   0,0,0,0,   ob_bus(1,0,2,0));
        tbl[8]  = mk(1,0,2,0,   0,0,0,0,   ob_ack(0,D0,0));
        tbl[9]  = mk(1,0,1,0,   1,0,2,0,   '0);
        tbl[10] = mk(1,0,1,0,   1,0,2,0,   ob_bus(1,0,2,0));
        tbl[11] = mk(1,0,1,0,   1,0,2,0,   ob_ack(1,D0,0));
        tbl[12] = mk(1,0,1,0,   0,0,0,0,   ob_bus(1,0,1,0));
        tbl[13] = mk(1,0,1,0,   0,0,0,0,   ob_ack(0,D1,0));
        tbl[14] = mk(0,0,0,0,   1,0,4,0,   '0);
        tbl[15] = mk(0,0,0,0,   1,0,4,0,   '0);
        tbl[16] = mk(0,0,0,0,   0,0,0,0,   ob_ack(1,0,1));
        tbl[17] = mk(0,0,0,0,   1,1,3,D3,  '0);
        tbl[18] = mk(0,0,0,0,   1,1,3,D3,  ob_bus(0,1,3,D3));
        tbl[19] = mk(0,0,0,0,   0,0,0,0,   ob_ack(1,0,0));

        repeat (3) begin
            @(negedge clk); #1;
            chk_obs("in reset", sample_a(), '0);
        end
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk_obs($sformatf("idle%0d", i), sample_a(), '0);
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            a_if.m0_req = tbl[i].r0; a_if.m0_we = tbl[i].w0;
            a_if.m0_addr = tbl[i].ad0; a_if.m0_wd = tbl[i].wd0;
            a_if.m1_req = tbl[i].r1; a_if.m1_we = tbl[i].w1;
            a_if.m1_addr = tbl[i].ad1; a_if.m1_wd = tbl[i].wd1;
            #1;
            chk_obs($sformatf("vec%0d", i), sample_a(), tbl[i].exp);
        end
        drop_all();
        repeat (2) @(negedge clk);
        chk("mem2", mem[2], D0);
        chk("mem3", mem[3], D3);

        b_read(30'd8, 32'h0, 1'b1, 30'd0, "b word8");
        b_read(30'd3, 32'h0, 1'b1, 30'd0, "b word3");
        b_read(30'd4, DB, 1'b0, 30'd0, "b word4");
        b_read(30'd7, DB, 1'b0, 30'd3, "b word7");

        @(negedge clk);
        a_if.m0_req = 1; a_if.m0_we = 0; a_if.m0_addr = 2;
        a_if.m1_req = 1; a_if.m1_we = 0; a_if.m1_addr = 3;
        n = 0; last_c = 0; n_prev = 1'b0;
        for (int c = 0; c < 100 && n < 20; c++) begin
            @(negedge clk); #1;
            if (a_if.m0_ack || a_if.m1_ack) begin
                cur = a_if.m1_ack;
                chk("load dual ack", {31'b0, a_if.m0_ack & a_if.m1_ack}, 32'd0);
                chk("load rd", cur ? a_if.m1_rd : a_if.m0_rd, cur ? D3 : D0);
                if (n > 0) begin
                    chk("load alternate", {31'b0, cur}, {31'b0, !n_prev});
                    chk("load gap", 32'(c - last_c), 32'd2);
                end
                n_prev = cur;
                last_c = c;
                n++;
            end
        end
        a_if.m0_req = 0; a_if.m1_req = 0;
        chk("load count", 32'(n), 32'd20);
        repeat (3) @(negedge clk);

        @(negedge clk);
        a_if.m0_req = 1; a_if.m0_we = 1; a_if.m0_addr = 1; a_if.m0_wd = 32'hCAFEF00D;
        @(posedge clk); #2;
        chk("rst bus_we before", {31'b0, a_if.bus_we}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst bus_we drop", {31'b0, a_if.bus_we}, 32'd0);
        acked = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            acked |= a_if.m0_ack | a_if.m1_ack;
            a_if.m0_req = 0;
        end
        chk("rst no ack", {31'b0, acked}, 32'd0);
        chk("rst mem1 kept", mem[1], D1);
        @(negedge clk);
        reset = 1'b1;
        a_access(1'b1, 1'b0, 30'd1, 32'h0, D1, "post-rst m1 read");
        a_access(1'b0, 1'b0, 30'd2, 32'h0, D0, "post-rst m0 read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
